// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory slave port.
// Each grant returns through IDLE, and a transaction ends on ack, abort or timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_write_en,
  input  logic        m1_write_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_dout,
  input  logic [31:0] m1_dout,
  input  logic [1:0]  m0_width,
  input  logic [1:0]  m1_width,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_din,
  output logic [31:0] m1_din,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  output logic [1:0]  mem_width,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        last_owner_reg, last_owner_next;
  logic [7:0]  count_reg, count_next;

  logic [1:0]  req;
  logic [1:0]  write_en;
  logic [31:0] addr [2];
  logic [31:0] dout [2];
  logic [1:0]  width [2];

  logic        busy;
  logic        sel;
  logic        sel_req;
  logic        sel_ack;
  logic        sel_err;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic [1:0]  err;

  assign req      = {m1_req, m0_req};
  assign write_en = {m1_write_en, m0_write_en};
  assign addr[0]  = m0_addr;
  assign addr[1]  = m1_addr;
  assign dout[0]  = m0_dout;
  assign dout[1]  = m1_dout;
  assign width[0] = m0_width;
  assign width[1] = m1_width;

  assign busy    = (state_reg != IDLE);
  assign sel     = (state_reg == BUSY1);
  assign sel_req = busy & req[sel];
  assign sel_ack = sel_req & mem_ack;
  // A late mem_ack in the final allowed cycle still completes the access.
  assign sel_err = sel_req & ~mem_ack & (count_reg == TIMEOUT_LAST);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign gnt[gi] = busy & (sel == 1'(gi));
      assign ack[gi] = sel_ack & (sel == 1'(gi));
      assign err[gi] = sel_err & (sel == 1'(gi));
    end
  endgenerate

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign m0_ack = ack[0];
  assign m1_ack = ack[1];
  assign m0_err = err[0];
  assign m1_err = err[1];
  assign m0_din = ack[0] ? mem_din : 32'd0;
  assign m1_din = ack[1] ? mem_din : 32'd0;

  always_comb begin
    mem_addr     = 32'd0;
    mem_dout     = 32'd0;
    mem_width    = 2'd0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (busy) begin
      mem_addr     = addr[sel];
      mem_dout     = dout[sel];
      mem_width    = width[sel];
      mem_read_en  = sel_req & ~write_en[sel];
      mem_write_en = sel_req & write_en[sel];
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    count_next      = count_reg;
    case (state_reg)
      IDLE: begin
        count_next = 8'd0;
        if (req == 2'b11) begin
          state_next = last_owner_reg ? BUSY0 : BUSY1;
        end else if (req[0]) begin
          state_next = BUSY0;
        end else if (req[1]) begin
          state_next = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (!sel_req || sel_ack || sel_err) begin
          state_next      = IDLE;
          last_owner_next = sel;
          count_next      = 8'd0;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      count_reg      <= 8'd0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      count_reg      <= count_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr [2];
  logic [31:0] dout [2];
  logic [1:0]  wid [2];
  logic [31:0] mem_din;
  logic        mem_ack;

  logic        m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_din, m1_din, mem_addr, mem_dout;
  logic [1:0]  mem_width;
  logic        mem_read_en, mem_write_en;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_write_en(wr[0]), .m1_write_en(wr[1]),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m0_dout(dout[0]), .m1_dout(dout[1]),
    .m0_width(wid[0]), .m1_width(wid[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err),
    .m0_din(m0_din), .m1_din(m1_din),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_width(mem_width),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_din(mem_din), .mem_ack(mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: who owns the bus (-1 = nobody), how many BUSY cycles it has used,
  // and who finished last.
  int owner;
  int age;
  int last;

  logic [1:0]  e_gnt, e_ack, e_err, e_en, done;
  logic [31:0] e_din [2];
  logic [31:0] e_addr, e_dout;
  logic [1:0]  e_width;

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    owner = -1;
    age   = 0;
    last  = 1;
    done  = 2'b00;
  endtask

  // Predict and compare outputs for the current cycle's inputs.
  task automatic settle();
    #1;
    if (!reset) model_reset();
    e_gnt = 2'b00; e_ack = 2'b00; e_err = 2'b00; e_en = 2'b00;
    e_din[0] = 32'd0; e_din[1] = 32'd0;
    e_addr = 32'd0; e_dout = 32'd0; e_width = 2'd0;
    if (owner >= 0) begin
      e_gnt[owner] = 1'b1;
      e_addr  = addr[owner];
      e_dout  = dout[owner];
      e_width = wid[owner];
      e_en    = {req[owner] & ~wr[owner], req[owner] & wr[owner]};
      e_ack[owner] = req[owner] & mem_ack;
      e_err[owner] = req[owner] & ~mem_ack & (age + 1 == TO);
      if (e_ack[owner]) e_din[owner] = mem_din;
    end
    chk("gnt",       {m1_gnt, m0_gnt}, e_gnt);
    chk("ack",       {m1_ack, m0_ack}, e_ack);
    chk("err",       {m1_err, m0_err}, e_err);
    chk("m0_din",    m0_din, e_din[0]);
    chk("m1_din",    m1_din, e_din[1]);
    chk("mem_addr",  mem_addr, e_addr);
    chk("mem_dout",  mem_dout, e_dout);
    chk("mem_width", mem_width, e_width);
    chk("mem_en",    {mem_read_en, mem_write_en}, e_en);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (owner < 0) begin
      if (req == 2'b11)  owner = 1 - last;
      else if (req[0])   owner = 0;
      else if (req[1])   owner = 1;
      age = 0;
    end else if (!req[owner] || e_ack[owner] || e_err[owner]) begin
      last  = owner;
      owner = -1;
    end else begin
      age++;
    end
    done = e_ack | e_err;
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0; req = 2'b00; wr = 2'b00; mem_ack = 1'b0; mem_din = 32'd0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'd0; dout[i] = 32'd0; wid[i] = 2'd0;
    end
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b1;

    // Post-reset tie goes to m0, then the next tie to m1.
    req = 2'b11; addr[0] = 32'h10; addr[1] = 32'h100;
    cycle();
    settle(); chk("dir_tie_gnt", {m1_gnt, m0_gnt}, 2'b01); tick();
    mem_ack = 1'b1; mem_din = 32'hA5A5_0000;
    settle(); chk("dir_m0_ack", m0_ack, 1'b1); tick();
    mem_ack = 1'b0;
    cycle();
    settle(); chk("dir_rr_gnt", {m1_gnt, m0_gnt}, 2'b10); tick();

    // m1 read completing in its second BUSY cycle.
    mem_ack = 1'b1; mem_din = 32'hDEAD_BEEF;
    settle();
    chk("dir_m1_din", m1_din, 32'hDEAD_BEEF);
    chk("dir_rd_en", {mem_read_en, mem_write_en}, 2'b10);
    tick();

    // m0 write with width 2.
    mem_ack = 1'b0; req = 2'b01; wr[0] = 1'b1;
    addr[0] = 32'h40; dout[0] = 32'h1234_5678; wid[0] = 2'd2;
    settle(); chk("dir_din_after", m1_din, 32'd0); tick();
    settle();
    chk("dir_wr_bus", {mem_addr, mem_dout}, {32'h40, 32'h1234_5678});
    chk("dir_wr_width", mem_width, 2'd2);
    chk("dir_wr_en", {mem_read_en, mem_write_en}, 2'b01);
    tick();
    mem_ack = 1'b1;
    cycle();

    // Timeout on m0 with m1 pending.
    mem_ack = 1'b0; req = 2'b01; wr[0] = 1'b0;
    cycle();
    req = 2'b11;
    cycle(); cycle(); cycle();
    settle(); chk("dir_timeout_err", {m1_err, m0_err}, 2'b01); tick();
    req = 2'b10;
    cycle();
    settle(); chk("dir_pending_gnt", {m1_gnt, m0_gnt}, 2'b10); tick();

    // m1 abandons in its second BUSY cycle.
    req = 2'b00;
    settle();
    chk("dir_abort_en", {mem_read_en, mem_write_en}, 2'b00);
    chk("dir_abort_ackerr", {m1_ack, m0_ack, m1_err, m0_err}, 4'b0000);
    tick();
    settle(); chk("dir_abort_idle", {m1_gnt, m0_gnt}, 2'b00); tick();

    // Reset in the middle of BUSY0.
    req = 2'b01;
    cycle();
    cycle();
    reset = 1'b0;
    settle(); chk("dir_rst_gnt", {m1_gnt, m0_gnt}, 2'b00); tick();
    reset = 1'b1; req = 2'b11;
    cycle();
    settle(); chk("dir_rst_tie", {m1_gnt, m0_gnt}, 2'b01); tick();
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0; req = 2'b00;
    cycle();

    // Random traffic: requesters hold until ack/err, occasionally abandon.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int n = 0; n < 2; n++) begin
        if (done[n]) begin
          req[n] = 1'b0;
        end else if (!req[n]) begin
          if ($urandom_range(0, 9) < 4) begin
            req[n]  = 1'b1;
            wr[n]   = 1'($urandom);
            addr[n] = $urandom;
            dout[n] = $urandom;
            wid[n]  = 2'($urandom);
          end
        end else if (owner == n && $urandom_range(0, 15) == 0) begin
          req[n] = 1'b0;
        end
      end
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_din = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
